// File: rtl/mask_row_serializer.sv
// Buffers parallel exposure-mask rows and serializes each onto a laneWidth-bit valid/ready bus.
// Build option: define MASK_ROW_PARITY_EN to append one parity beat per row.
module mask_row_serializer #(
  parameter int unsigned maxImageSensorCols = 64,
  parameter int unsigned laneWidth          = 8,
  parameter int unsigned FIFO_DEPTH         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic [1:0]                    imageSensorResolution,
  input  logic [maxImageSensorCols-1:0] mg_mask,
  input  logic                          rp_valid,
  output logic                          ms_ready,
  output logic                          ms_overflow,
  output logic [laneWidth-1:0]          sensor_data,
  output logic                          sensor_valid,
  input  logic                          sensor_ready,
  output logic                          sensor_row_start,
  output logic                          sensor_frame_start,
  output logic [5:0]                    sensor_row_addr,
  output logic                          sensor_latch,
  output logic                          sensor_parity
);

  localparam int unsigned COLS   = maxImageSensorCols;
  localparam int unsigned LW     = laneWidth;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BEAT_W = 7;
  localparam int unsigned ROW_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH
`ifdef MASK_ROW_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [COLS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [COLS-1:0]   shreg_q, shreg_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        res_q, res_d;
  logic              ovf_q;
  logic              valid_q, row_start_q, frame_start_q, latch_q;
  logic              valid_d, row_start_d, frame_start_d, latch_d;
`ifdef MASK_ROW_PARITY_EN
  logic              par_q, par_d;
  logic              par_flag_q, par_flag_d;
`endif

  logic              push_c, pop_c, full_c, empty_c;
  logic [1:0]        load_res_c;
  logic [6:0]        act_cols_c, load_cols_c;
  logic [BEAT_W-1:0] last_beat_c;
  logic [ROW_W-1:0]  last_row_c;
  logic [COLS-1:0]   col_mask_c, head_masked_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Row FIFO handshake; a pop frees a slot in the same cycle
  assign full_c   = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_c  = (cnt_q == '0);
  assign pop_c    = clk_en && (state_q == S_LOAD);
  assign ms_ready = !full_c || pop_c;
  assign push_c   = clk_en && rp_valid && ms_ready;

  // Frame geometry: active frame from res_q, row being loaded may resample at row 0
  assign act_cols_c    = {3'(res_q) + 3'd1, 4'b0000};
  assign last_beat_c   = BEAT_W'(act_cols_c / 7'(LW)) - BEAT_W'(1);
  assign last_row_c    = ROW_W'(act_cols_c - 7'd1);
  assign load_res_c    = (row_q == '0) ? imageSensorResolution : res_q;
  assign load_cols_c   = {3'(load_res_c) + 3'd1, 4'b0000};
  assign head_masked_c = mem_q[rd_ptr_q] & col_mask_c;

  always_comb begin : col_mask_gen
    col_mask_c = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      col_mask_c[i] = (i < 32'(load_cols_c));
    end
  end

  always_ff @(posedge clk) begin : fifo_mem
    if (push_c) mem_q[wr_ptr_q] <= mg_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin : fifo_ctrl
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (clk_en) begin
      if (push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      if (rp_valid && !ms_ready) ovf_q <= 1'b1;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    res_d   = res_q;
    shreg_d = shreg_q;
`ifdef MASK_ROW_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: if (!empty_c) state_d = S_LOAD;
      S_LOAD: begin
        if (row_q == '0) res_d = imageSensorResolution;
        shreg_d = head_masked_c;
`ifdef MASK_ROW_PARITY_EN
        par_d   = ^head_masked_c;
`endif
        beat_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (sensor_ready) begin
          // Inactive columns were masked at load, so shifting empties the register
          shreg_d = shreg_q >> LW;
          beat_d  = beat_q + BEAT_W'(1);
          if (beat_q == last_beat_c) begin
`ifdef MASK_ROW_PARITY_EN
            shreg_d = COLS'(par_q);
            state_d = S_PARITY;
`else
            state_d = S_LATCH;
`endif
          end
        end
      end
`ifdef MASK_ROW_PARITY_EN
      S_PARITY: begin
        if (sensor_ready) begin
          shreg_d = '0;
          state_d = S_LATCH;
        end
      end
`endif
      S_LATCH: begin
        row_d   = (row_q == last_row_c) ? '0 : row_q + ROW_W'(1);
        state_d = empty_c ? S_IDLE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d       = (state_d == S_SHIFT);
`ifdef MASK_ROW_PARITY_EN
    valid_d       = valid_d || (state_d == S_PARITY);
    par_flag_d    = (state_d == S_PARITY);
`endif
    row_start_d   = (state_d == S_SHIFT) && (beat_d == '0);
    frame_start_d = row_start_d && (row_d == '0);
    latch_d       = (state_d == S_LATCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
    if (!rst_n) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      row_q         <= '0;
      res_q         <= '0;
      shreg_q       <= '0;
      valid_q       <= 1'b0;
      row_start_q   <= 1'b0;
      frame_start_q <= 1'b0;
      latch_q       <= 1'b0;
`ifdef MASK_ROW_PARITY_EN
      par_q         <= 1'b0;
      par_flag_q    <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      row_q         <= row_d;
      res_q         <= res_d;
      shreg_q       <= shreg_d;
      valid_q       <= valid_d;
      row_start_q   <= row_start_d;
      frame_start_q <= frame_start_d;
      latch_q       <= latch_d;
`ifdef MASK_ROW_PARITY_EN
      par_q         <= par_d;
      par_flag_q    <= par_flag_d;
`endif
    end
  end

  assign ms_overflow        = ovf_q;
  assign sensor_data        = shreg_q[LW-1:0];
  assign sensor_valid       = valid_q;
  assign sensor_row_start   = row_start_q;
  assign sensor_frame_start = frame_start_q;
  assign sensor_row_addr    = row_q;
  assign sensor_latch       = latch_q;
`ifdef MASK_ROW_PARITY_EN
  assign sensor_parity      = par_flag_q;
`else
  assign sensor_parity      = 1'b0;
`endif

endmodule

// File: tb/tb_mask_row_serializer.sv
// Self-checking bench for mask_row_serializer: transaction-level reference model plus directed literals.
module tb_mask_row_serializer;

  localparam int unsigned COLS  = 64;
  localparam int unsigned LW    = 8;
  localparam int          DEPTH = 2;
`ifdef MASK_ROW_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [63:0] LANE_MASK = (64'd1 << LW) - 64'd1;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_SHIFT = 2, PH_PARITY = 3, PH_LATCH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clk_en;
  logic [1:0]      imageSensorResolution;
  logic [COLS-1:0] mg_mask;
  logic            rp_valid;
  logic            ms_ready, ms_overflow;
  logic [LW-1:0]   sensor_data;
  logic            sensor_valid, sensor_ready;
  logic            sensor_row_start, sensor_frame_start;
  logic [5:0]      sensor_row_addr;
  logic            sensor_latch, sensor_parity;

  mask_row_serializer #(
    .maxImageSensorCols(COLS), .laneWidth(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .imageSensorResolution(imageSensorResolution), .mg_mask(mg_mask),
    .rp_valid(rp_valid), .ms_ready(ms_ready), .ms_overflow(ms_overflow),
    .sensor_data(sensor_data), .sensor_valid(sensor_valid), .sensor_ready(sensor_ready),
    .sensor_row_start(sensor_row_start), .sensor_frame_start(sensor_frame_start),
    .sensor_row_addr(sensor_row_addr), .sensor_latch(sensor_latch), .sensor_parity(sensor_parity)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of buffered rows plus the row currently on the wire
  logic [63:0] m_fifo[$];
  int          m_phase, m_beat, m_row;
  logic [1:0]  m_res;
  logic [63:0] m_cur;
  bit          m_ovf;

  logic [1:0]  res_v;
  logic [63:0] acc_q[$];
  int          lat_q[$];
  int          n_latch, n_frame, n_par;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cols_of(input logic [1:0] r);
    return 16 * (int'(r) + 1);
  endfunction

  function automatic logic [63:0] cols_mask(input logic [1:0] r);
    int c;
    c = cols_of(r);
    return (c >= 64) ? '1 : ((64'd1 << c) - 64'd1);
  endfunction

  function automatic bit exp_ready(input bit ce);
    return (m_fifo.size() < DEPTH) || (m_phase == PH_LOAD && ce);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_phase = PH_IDLE; m_beat = 0; m_row = 0; m_res = 2'b00; m_cur = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit rdy, nonempty;
    int nxt;
    if (!clk_en) return;
    rdy      = exp_ready(1'b1);
    nonempty = (m_fifo.size() != 0);
    nxt      = m_phase;
    case (m_phase)
      PH_IDLE: if (nonempty) nxt = PH_LOAD;
      PH_LOAD: begin
        if (m_row == 0) m_res = imageSensorResolution;
        m_cur  = m_fifo.pop_front() & cols_mask(m_res);
        m_beat = 0;
        nxt    = PH_SHIFT;
      end
      PH_SHIFT: if (sensor_ready) begin
        m_beat++;
        if (m_beat == cols_of(m_res) / int'(LW)) nxt = PAR_EN ? PH_PARITY : PH_LATCH;
      end
      PH_PARITY: if (sensor_ready) nxt = PH_LATCH;
      PH_LATCH: begin
        m_row = (m_row + 1) % cols_of(m_res);
        nxt   = nonempty ? PH_LOAD : PH_IDLE;
      end
      default: nxt = PH_IDLE;
    endcase
    if (rp_valid) begin
      if (rdy) m_fifo.push_back(mg_mask);
      else m_ovf = 1'b1;
    end
    m_phase = nxt;
  endtask

  task automatic check_outputs();
    logic [63:0] e_data;
    bit e_valid, e_rs;
    e_valid = (m_phase == PH_SHIFT) || (m_phase == PH_PARITY);
    e_rs    = (m_phase == PH_SHIFT) && (m_beat == 0);
    e_data  = '0;
    if (m_phase == PH_SHIFT) e_data = (m_cur >> (m_beat * int'(LW))) & LANE_MASK;
    else if (m_phase == PH_PARITY) e_data = 64'($countones(m_cur) % 2);
    chk("sensor_valid", 64'(sensor_valid), 64'(e_valid));
    chk("sensor_data", 64'(sensor_data), e_data);
    chk("row_start", 64'(sensor_row_start), 64'(e_rs));
    chk("frame_start", 64'(sensor_frame_start), 64'(e_rs && m_row == 0));
    chk("row_addr", 64'(sensor_row_addr), 64'(m_row));
    chk("latch", 64'(sensor_latch), 64'(m_phase == PH_LATCH));
    chk("parity_flag", 64'(sensor_parity), 64'(m_phase == PH_PARITY));
    chk("overflow", 64'(ms_overflow), 64'(m_ovf));
  endtask

  // One clock: drive at negedge, check ms_ready, step model at posedge, check outputs at negedge
  task automatic cycle(input bit ce_i, input bit rv_i, input logic [63:0] m_i, input bit sr_i);
    clk_en = ce_i; rp_valid = rv_i; mg_mask = m_i; sensor_ready = sr_i;
    imageSensorResolution = res_v;
    #1;
    chk("ms_ready", 64'(ms_ready), 64'(exp_ready(ce_i)));
    if (ce_i && sr_i && sensor_valid) acc_q.push_back(64'(sensor_data));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (sensor_latch) begin
      n_latch++;
      lat_q.push_back(int'(sensor_row_addr));
    end
    n_frame += int'(sensor_frame_start);
    n_par   += int'(sensor_parity);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clk_en = 1'b0; rp_valid = 1'b0; sensor_ready = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("ms_ready_rst", 64'(ms_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc_q.delete(); lat_q.delete();
    n_latch = 0; n_frame = 0; n_par = 0;
  endtask

  task automatic clear_obs();
    acc_q.delete(); lat_q.delete();
    n_latch = 0; n_frame = 0; n_par = 0;
  endtask

  initial begin
    int pushed;
    bit rv;
    rst_n = 1'b0; clk_en = 1'b0; rp_valid = 1'b0; sensor_ready = 1'b0;
    mg_mask = '0; res_v = 2'b11; imageSensorResolution = 2'b11;
    @(negedge clk);
    do_reset();

    // 64x64, F0 pattern, free-running sink
    res_v = 2'b11;
    cycle(1, 1, 64'hF0F0_F0F0_F0F0_F0F0, 1);
    cycle(1, 0, '0, 1);
    cycle(1, 0, '0, 1);
    chk("t1_row_start", 64'(sensor_row_start), 64'd1);
    chk("t1_frame_start", 64'(sensor_frame_start), 64'd1);
    chk("t1_first_beat", 64'(sensor_data), 64'hF0);
    clear_obs();
    repeat (12) cycle(1, 0, '0, 1);
    chk("t1_beat_count", 64'(acc_q.size()), PAR_EN ? 64'd9 : 64'd8);
    for (int i = 0; i < 8 && i < acc_q.size(); i++) chk("t1_beat_data", acc_q[i], 64'hF0);
    chk("t1_latch_count", 64'(n_latch), 64'd1);
    if (lat_q.size() > 0) chk("t1_latch_addr", 64'(lat_q[0]), 64'd0);

    // Alternating sink ready: eight beats over sixteen cycles
    do_reset();
    cycle(1, 1, 64'hF0F0_F0F0_F0F0_F0F0, 1);
    cycle(1, 0, '0, 1);
    cycle(1, 0, '0, 1);
    clear_obs();
    for (int i = 0; i < 16; i++) cycle(1, 0, '0, (i % 2) == 0);
    chk("t2_beat_count", 64'(acc_q.size()), 64'd8);
    for (int i = 0; i < acc_q.size(); i++) chk("t2_beat_data", acc_q[i], 64'hF0);

    // Stalled sink: FIFO fills, later row is dropped, overflow is sticky
    do_reset();
    cycle(1, 1, 64'h1111_1111_1111_1111, 0);
    cycle(1, 1, 64'h2222_2222_2222_2222, 0);
    cycle(1, 1, 64'h3333_3333_3333_3333, 0);
    chk("t3_no_overflow_yet", 64'(ms_overflow), 64'd0);
    chk("t3_ready_low", 64'(ms_ready), 64'd0);
    cycle(1, 1, 64'h4444_4444_4444_4444, 0);
    chk("t3_overflow", 64'(ms_overflow), 64'd1);
    clear_obs();
    repeat (60) cycle(1, 0, '0, 1);
    chk("t3_rows_sent", 64'(n_latch), 64'd3);
    chk("t3_overflow_sticky", 64'(ms_overflow), 64'd1);

    // 16x16 frame: 17 rows, row address wraps, frame start twice
    do_reset();
    res_v = 2'b00;
    pushed = 0;
    repeat (150) begin
      rv = (pushed < 17) && exp_ready(1'b1);
      cycle(1, rv, 64'hFFFF_FFFF_FFFF_0000 | 64'($urandom_range(0, 65535)), 1);
      if (rv) pushed++;
    end
    chk("t4_pushed", 64'(pushed), 64'd17);
    chk("t4_latches", 64'(n_latch), 64'd17);
    chk("t4_frame_starts", 64'(n_frame), 64'd2);
    chk("t4_beats", 64'(acc_q.size()), PAR_EN ? 64'd51 : 64'd34);
    if (lat_q.size() == 17) begin
      chk("t4_addr_15", 64'(lat_q[15]), 64'd15);
      chk("t4_addr_wrap", 64'(lat_q[16]), 64'd0);
    end

    // Clock-enable freeze mid-row, then reset mid-row
    do_reset();
    res_v = 2'b11;
    cycle(1, 1, 64'hF0F0_F0F0_F0F0_F0F0, 1);
    repeat (3) cycle(1, 0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      chk("t5_frozen_valid", 64'(sensor_valid), 64'd1);
      chk("t5_frozen_data", 64'(sensor_data), 64'hF0);
      chk("t5_frozen_rs", 64'(sensor_row_start), 64'd0);
    end
    do_reset();
    chk("t5_rst_valid", 64'(sensor_valid), 64'd0);
    chk("t5_rst_latch", 64'(sensor_latch), 64'd0);
    cycle(1, 1, 64'hA5A5_A5A5_A5A5_A5A5, 1);
    cycle(1, 0, '0, 1);
    cycle(1, 0, '0, 1);
    chk("t5_next_addr", 64'(sensor_row_addr), 64'd0);
    chk("t5_next_frame_start", 64'(sensor_frame_start), 64'd1);
    chk("t5_next_data", 64'(sensor_data), 64'hA5);

    // Row with five ones: parity beat only in the parity build
    do_reset();
    res_v = 2'b11;
    cycle(1, 1, 64'h0000_0000_0000_001F, 1);
    cycle(1, 0, '0, 1);
    cycle(1, 0, '0, 1);
    clear_obs();
    repeat (12) cycle(1, 0, '0, 1);
    chk("t6_beat_count", 64'(acc_q.size()), PAR_EN ? 64'd9 : 64'd8);
    if (acc_q.size() > 0) chk("t6_beat0", acc_q[0], 64'h1F);
    if (PAR_EN && acc_q.size() == 9) chk("t6_parity_beat", acc_q[8], 64'h01);
    chk("t6_parity_flags", 64'(n_par), PAR_EN ? 64'd1 : 64'd0);
    chk("t6_latch", 64'(n_latch), 64'd1);

    // Randomized traffic with resolution changes and occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 49) == 0) res_v = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 4,
            {$urandom, $urandom}, $urandom_range(0, 9) < 7);
      if (acc_q.size() > 256) clear_obs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
